// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings and
// default stage indices of the 5-stage in-order pipeline.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        PHC_RUN      = 2'd0,
        PHC_MEM_WAIT = 2'd1,
        PHC_ERROR    = 2'd2
    } phc_state_e;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = STG_IF + 1;
    localparam int STG_EX  = STG_ID + 1;
    localparam int STG_MEM = STG_EX + 1;
    localparam int STG_WB  = STG_MEM + 1;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive data-memory wait cycles and raises a sticky error once
// the wait exceeds MEM_TIMEOUT cycles without an acknowledge.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_start,
    input  logic i_in_wait,
    input  logic i_mem_wait,
    output logic o_timeout,
    output logic o_err
);

    // +2 keeps the counter at least one bit wide even for MEM_TIMEOUT=0
    localparam int CW = $clog2(MEM_TIMEOUT + 2);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    assign o_timeout = i_in_wait & i_mem_wait & (r_cnt == CW'(MEM_TIMEOUT));
    assign o_err     = r_err;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (i_start)
                r_cnt <= CW'(1);
            else if (i_in_wait && i_mem_wait && !o_timeout)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
            if (o_timeout)
                r_err <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: resolves memory wait, multi-cycle EX, jump
// redirect and load-use hazards into per-register stall/flush vectors.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int REG_AW      = 5,
    parameter int NUM_STAGES  = STG_WB + 1,
    parameter int EX_STAGE    = STG_EX,
    parameter int MEM_STAGE   = STG_MEM,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  JumpFlagFromEx,
    input  logic [XLEN-1:0]       JumpAddrFromEx,
    input  logic [REG_AW-1:0]     IdRs1Addr,
    input  logic                  IdRs1ReadEnable,
    input  logic [REG_AW-1:0]     IdRs2Addr,
    input  logic                  IdRs2ReadEnable,
    input  logic [REG_AW-1:0]     ExRdAddr,
    input  logic                  ExRdWriteEnable,
    input  logic                  ExIsLoad,
    input  logic                  ExBusy,
    input  logic                  MemReq,
    input  logic                  MemAck,
    output logic                  JumpFlagToPc,
    output logic [XLEN-1:0]       JumpAddrToPc,
    output logic [NUM_STAGES-1:0] StallOut,
    output logic [NUM_STAGES-1:0] FlushOut,
    output logic                  MemTimeout,
    output logic [CNT_W-1:0]      StallCycles,
    output logic [CNT_W-1:0]      FlushCount
);

    phc_state_e r_state, w_state_nxt;

    logic w_mem_wait, w_load_use, w_err, w_timeout;
    logic w_c_err, w_c_mem, w_c_ex, w_c_jmp, w_c_lu;
    logic [NUM_STAGES-1:0] w_stall, w_flush;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    assign w_mem_wait = MemReq & ~MemAck;
    assign w_err      = (r_state == PHC_ERROR);
    assign w_load_use = ExIsLoad & ExRdWriteEnable & (ExRdAddr != '0) &
                        ((IdRs1ReadEnable & (IdRs1Addr == ExRdAddr)) |
                         (IdRs2ReadEnable & (IdRs2Addr == ExRdAddr)));

    // One-hot cause select; everything is forced low while reset is held
    assign w_c_err = Rst & w_err;
    assign w_c_mem = Rst & ~w_err & w_mem_wait;
    assign w_c_ex  = Rst & ~w_err & ~w_mem_wait & ExBusy;
    assign w_c_jmp = Rst & ~w_err & ~w_mem_wait & ~ExBusy & JumpFlagFromEx;
    assign w_c_lu  = Rst & ~w_err & ~w_mem_wait & ~ExBusy & ~JumpFlagFromEx & w_load_use;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stg
        localparam logic LE_MEM = (i <= MEM_STAGE);
        localparam logic LE_EX  = (i <= EX_STAGE);
        localparam logic LE_ID  = (i <= EX_STAGE - 1);
        localparam logic AT_MEM = (i == MEM_STAGE + 1);
        localparam logic AT_EX  = (i == EX_STAGE + 1);
        localparam logic AT_ID  = (i == EX_STAGE);
        localparam logic IN_JMP = (i > STG_IF) && (i <= EX_STAGE);

        assign w_stall[i] = w_c_err | (w_c_mem & LE_MEM) | (w_c_ex & LE_EX) | (w_c_lu & LE_ID);
        assign w_flush[i] = (w_c_mem & AT_MEM) | (w_c_ex & AT_EX) |
                            (w_c_lu & AT_ID) | (w_c_jmp & IN_JMP);
    end

    assign StallOut     = w_stall;
    assign FlushOut     = w_flush;
    assign JumpFlagToPc = w_c_jmp;
    assign JumpAddrToPc = w_c_jmp ? JumpAddrFromEx : '0;
    assign StallCycles  = r_stall_cnt;
    assign FlushCount   = r_flush_cnt;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .Clk       (Clk),
        .Rst       (Rst),
        .i_start   ((r_state == PHC_RUN) & w_mem_wait),
        .i_in_wait (r_state == PHC_MEM_WAIT),
        .i_mem_wait(w_mem_wait),
        .o_timeout (w_timeout),
        .o_err     (MemTimeout)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PHC_RUN:      if (w_mem_wait) w_state_nxt = PHC_MEM_WAIT;
            PHC_MEM_WAIT: begin
                if (w_timeout)       w_state_nxt = PHC_ERROR;
                else if (!w_mem_wait) w_state_nxt = PHC_RUN;
            end
            PHC_ERROR:    w_state_nxt = PHC_ERROR;
            default:      w_state_nxt = PHC_RUN;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= PHC_RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_stall[0] && !w_err && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_c_jmp && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a cycle-level reference model
// derived from the hazard priority rules.
module tb_pipe_hazard_ctrl;

    localparam int NS  = 5;
    localparam int EX  = 2;
    localparam int MEM = 3;
    localparam int TO  = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          JumpFlagFromEx = 0;
    logic [63:0]   JumpAddrFromEx = '0;
    logic [4:0]    IdRs1Addr = '0, IdRs2Addr = '0, ExRdAddr = '0;
    logic          IdRs1ReadEnable = 0, IdRs2ReadEnable = 0;
    logic          ExRdWriteEnable = 0, ExIsLoad = 0, ExBusy = 0, MemReq = 0, MemAck = 0;
    logic          JumpFlagToPc, MemTimeout;
    logic [63:0]   JumpAddrToPc;
    logic [NS-1:0] StallOut, FlushOut;
    logic [CW-1:0] StallCycles, FlushCount;

    int n_chk = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(.XLEN(64), .REG_AW(5), .NUM_STAGES(NS), .EX_STAGE(EX), .MEM_STAGE(MEM),
                       .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .Clk(Clk), .Rst(Rst),
        .JumpFlagFromEx(JumpFlagFromEx), .JumpAddrFromEx(JumpAddrFromEx),
        .IdRs1Addr(IdRs1Addr), .IdRs1ReadEnable(IdRs1ReadEnable),
        .IdRs2Addr(IdRs2Addr), .IdRs2ReadEnable(IdRs2ReadEnable),
        .ExRdAddr(ExRdAddr), .ExRdWriteEnable(ExRdWriteEnable), .ExIsLoad(ExIsLoad),
        .ExBusy(ExBusy), .MemReq(MemReq), .MemAck(MemAck),
        .JumpFlagToPc(JumpFlagToPc), .JumpAddrToPc(JumpAddrToPc),
        .StallOut(StallOut), .FlushOut(FlushOut), .MemTimeout(MemTimeout),
        .StallCycles(StallCycles), .FlushCount(FlushCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: error flag, run length of un-acked wait cycles, counters
    bit m_err;
    int m_wait, m_sc, m_fc;

    // -1 no action, -2 redirect, -3 error, otherwise the hold stage
    function automatic int cause_k();
        if (!Rst) return -1;
        if (m_err) return -3;
        if (MemReq && !MemAck) return MEM;
        if (ExBusy) return EX;
        if (JumpFlagFromEx) return -2;
        if (ExIsLoad && ExRdWriteEnable && ExRdAddr != 0 &&
            ((IdRs1ReadEnable && IdRs1Addr == ExRdAddr) ||
             (IdRs2ReadEnable && IdRs2Addr == ExRdAddr))) return EX - 1;
        return -1;
    endfunction

    always @(posedge Clk or negedge Rst) begin
        int k;
        if (!Rst) begin
            m_err = 0; m_wait = 0; m_sc = 0; m_fc = 0;
        end else begin
            k = cause_k();
            if (k != -3) begin
                if (k >= 0 && m_sc < SAT) m_sc++;
                if (k == -2 && m_fc < SAT) m_fc++;
                if (MemReq && !MemAck) begin
                    m_wait++;
                    if (m_wait == TO + 1) m_err = 1;
                end else
                    m_wait = 0;
            end
        end
    end

    always @(negedge Clk) begin
        int k;
        logic [NS-1:0] e_s, e_f;
        logic          e_j;
        logic [63:0]   e_a;
        k = cause_k();
        e_s = '0; e_f = '0; e_j = 0; e_a = '0;
        if (k == -3) e_s = '1;
        else if (k == -2) begin
            e_j = 1; e_a = JumpAddrFromEx;
            for (int i = 1; i <= EX; i++) e_f[i] = 1'b1;
        end else if (k >= 0) begin
            for (int i = 0; i <= k; i++) e_s[i] = 1'b1;
            e_f[k+1] = 1'b1;
        end
        chk("m_stall", {59'd0, StallOut}, {59'd0, e_s});
        chk("m_flush", {59'd0, FlushOut}, {59'd0, e_f});
        chk("m_jflag", {63'd0, JumpFlagToPc}, {63'd0, e_j});
        chk("m_jaddr", JumpAddrToPc, e_a);
        chk("m_tmo", {63'd0, MemTimeout}, {63'd0, m_err});
        chk("m_scnt", {60'd0, StallCycles}, 64'(m_sc));
        chk("m_fcnt", {60'd0, FlushCount}, 64'(m_fc));
    end

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    task automatic clr();
        JumpFlagFromEx = 0; JumpAddrFromEx = '0; IdRs1Addr = '0; IdRs2Addr = '0; ExRdAddr = '0;
        IdRs1ReadEnable = 0; IdRs2ReadEnable = 0; ExRdWriteEnable = 0; ExIsLoad = 0;
        ExBusy = 0; MemReq = 0; MemAck = 0;
    endtask

    task automatic rst_pulse();
        @(posedge Clk); #1; clr();
        #1 Rst = 0; #2 Rst = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #3;
        chk("rst_stall", {59'd0, StallOut}, 64'd0);
        chk("rst_tmo", {63'd0, MemTimeout}, 64'd0);
        #4 Rst = 1;

        // load-use on rs1, then rd=x0, then rs2
        rst_pulse();
        ExIsLoad = 1; ExRdWriteEnable = 1; ExRdAddr = 5; IdRs1Addr = 5; IdRs1ReadEnable = 1;
        @(negedge Clk);
        chk("lu_stall", {59'd0, StallOut}, 64'b00011);
        chk("lu_flush", {59'd0, FlushOut}, 64'b00100);
        tick(); ExRdAddr = 0; IdRs1Addr = 0;
        @(negedge Clk);
        chk("lu_x0_stall", {59'd0, StallOut}, 64'd0);
        tick(); ExRdAddr = 7; IdRs1ReadEnable = 0; IdRs2Addr = 7; IdRs2ReadEnable = 1;
        @(negedge Clk);
        chk("lu_rs2_stall", {59'd0, StallOut}, 64'b00011);
        tick(); clr();
        @(negedge Clk);
        chk("lu_scnt", {60'd0, StallCycles}, 64'd2);

        // jump overrides load-use
        rst_pulse();
        ExIsLoad = 1; ExRdWriteEnable = 1; ExRdAddr = 5; IdRs1Addr = 5; IdRs1ReadEnable = 1;
        JumpFlagFromEx = 1; JumpAddrFromEx = 64'h8000_0040;
        @(negedge Clk);
        chk("j_flag", {63'd0, JumpFlagToPc}, 64'd1);
        chk("j_addr", JumpAddrToPc, 64'h8000_0040);
        chk("j_flush", {59'd0, FlushOut}, 64'b00110);
        chk("j_stall", {59'd0, StallOut}, 64'd0);
        tick(); clr();
        @(negedge Clk);
        chk("j_fcnt", {60'd0, FlushCount}, 64'd1);
        chk("j_addr0", JumpAddrToPc, 64'd0);

        // EX busy defers jump
        rst_pulse();
        ExBusy = 1; JumpFlagFromEx = 1; JumpAddrFromEx = 64'h0000_1234_5678_9ABC;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            chk("exb_stall", {59'd0, StallOut}, 64'b00111);
            chk("exb_flush", {59'd0, FlushOut}, 64'b01000);
            chk("exb_noj", {63'd0, JumpFlagToPc}, 64'd0);
            tick();
        end
        ExBusy = 0;
        @(negedge Clk);
        chk("exb_jflag", {63'd0, JumpFlagToPc}, 64'd1);
        chk("exb_scnt", {60'd0, StallCycles}, 64'd4);
        tick(); clr();
        @(negedge Clk);
        chk("exb_jpulse", {63'd0, JumpFlagToPc}, 64'd0);
        chk("exb_fcnt", {60'd0, FlushCount}, 64'd1);

        // memory wait with ack after three cycles
        rst_pulse();
        MemReq = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            chk("mw_stall", {59'd0, StallOut}, 64'b01111);
            chk("mw_flush", {59'd0, FlushOut}, 64'b10000);
            tick();
        end
        MemAck = 1;
        @(negedge Clk);
        chk("mw_ack_stall", {59'd0, StallOut}, 64'd0);
        tick(); clr();
        @(negedge Clk);
        chk("mw_scnt", {60'd0, StallCycles}, 64'd3);

        // priority: MEM wait over EX busy over jump
        rst_pulse();
        MemReq = 1; ExBusy = 1; JumpFlagFromEx = 1; JumpAddrFromEx = 64'h40;
        @(negedge Clk);
        chk("pri_mem", {59'd0, StallOut}, 64'b01111);
        tick(); MemAck = 1;
        @(negedge Clk);
        chk("pri_ex", {59'd0, StallOut}, 64'b00111);
        tick(); MemReq = 0; MemAck = 0; ExBusy = 0;
        @(negedge Clk);
        chk("pri_j", {63'd0, JumpFlagToPc}, 64'd1);
        tick(); clr();

        // ack in the last permitted cycle avoids the error
        rst_pulse();
        MemReq = 1;
        repeat (TO) @(negedge Clk);
        tick(); MemAck = 1;
        @(negedge Clk);
        chk("edge_ack_stall", {59'd0, StallOut}, 64'd0);
        tick(); clr();
        @(negedge Clk);
        chk("edge_no_tmo", {63'd0, MemTimeout}, 64'd0);

        // timeout: five un-acked wait cycles then sticky error
        rst_pulse();
        MemReq = 1;
        for (int c = 0; c < TO + 1; c++) begin
            @(negedge Clk);
            chk("to_wait", {59'd0, StallOut}, 64'b01111);
            chk("to_notyet", {63'd0, MemTimeout}, 64'd0);
        end
        @(negedge Clk);
        chk("to_flag", {63'd0, MemTimeout}, 64'd1);
        chk("to_stall", {59'd0, StallOut}, 64'b11111);
        chk("to_flush", {59'd0, FlushOut}, 64'd0);
        chk("to_scnt", {60'd0, StallCycles}, 64'd5);
        tick(); MemAck = 1; ExBusy = 1;
        repeat (2) @(negedge Clk);
        chk("to_sticky", {63'd0, MemTimeout}, 64'd1);
        chk("to_sticky_stall", {59'd0, StallOut}, 64'b11111);
        chk("to_scnt_frozen", {60'd0, StallCycles}, 64'd5);
        @(posedge Clk); #2 Rst = 0; #1;
        chk("to_rst_flag", {63'd0, MemTimeout}, 64'd0);
        chk("to_rst_stall", {59'd0, StallOut}, 64'd0);
        chk("to_rst_scnt", {60'd0, StallCycles}, 64'd0);
        #1 Rst = 1;
        tick(); clr();

        // reset mid MEM_WAIT with EX busy
        rst_pulse();
        MemReq = 1; ExBusy = 1;
        repeat (2) @(negedge Clk);
        @(posedge Clk); #3 Rst = 0; #1;
        chk("r6_stall", {59'd0, StallOut}, 64'd0);
        chk("r6_flush", {59'd0, FlushOut}, 64'd0);
        chk("r6_scnt", {60'd0, StallCycles}, 64'd0);
        tick(); Rst = 1;
        @(negedge Clk);
        chk("r6_follow", {59'd0, StallOut}, 64'b01111);
        tick(); clr();

        // counter saturation
        rst_pulse();
        ExBusy = 1;
        repeat (SAT + 3) @(negedge Clk);
        chk("sat_scnt", {60'd0, StallCycles}, 64'(SAT));
        tick(); clr(); JumpFlagFromEx = 1; JumpAddrFromEx = 64'h100;
        repeat (SAT + 2) @(negedge Clk);
        chk("sat_fcnt", {60'd0, FlushCount}, 64'(SAT));
        tick(); clr();
        @(negedge Clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
